// File: rtl/uart_frame_pkg.sv
// Frame constants, slot/state encodings and PID helper for the UART frame path.
// Shared by the TX frame scheduler and the RX PID buffer.
package uart_frame_pkg;

    localparam logic [7:0] START_FRAME     = 8'hAA;
    localparam logic [7:0] END_FRAME       = 8'h55;
    localparam logic [7:0] TEST_PID        = 8'h69;
    localparam logic [7:0] PID_STRIDE      = 8'h10;
    localparam int         FRAMES_PER_WORD = 4;
    localparam logic [3:0] TEST_ID         = 4'hF;

    typedef enum logic [1:0] {
        SLOT_START,
        SLOT_PID,
        SLOT_VALUE,
        SLOT_END
    } slot_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP
    } state_e;

    // PID of frame `frame` for requester `id`: (id+1)*stride + frame
    function automatic logic [7:0] pid_of(input logic [3:0] id,
                                          input logic [1:0] frame);
        return PID_STRIDE * (8'(id) + 8'd1) + 8'(frame);
    endfunction

endpackage

// File: rtl/uart_tx_frame_sched_rr_arbiter.sv
// Round-robin arbiter: first set request at or after the pointer wins.
// Pointer moves to one past the served index when upd is strobed.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         upd,
    input  logic [3:0]   upd_idx,
    output logic [N-1:0] gnt,
    output logic [3:0]   gnt_idx,
    output logic         gnt_vld
);

    logic [3:0] ptr_q;
    logic [3:0] ptr_d;
    int         k;

    // next pointer: one past the served requester, wrapping at N
    always_comb begin
        ptr_d = ptr_q;
        if (upd) begin
            if (upd_idx == 4'(N - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = upd_idx + 4'd1;
            end
        end
    end

    // rotating priority search starting at the pointer
    always_comb begin
        k       = 0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr_q) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!gnt_vld && req[k]) begin
                gnt_vld = 1'b1;
                gnt_idx = 4'(k);
            end
        end
    end

    // one-hot view of the winning index
    always_comb begin
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = gnt_vld && (gnt_idx == 4'(i));
        end
    end

    // pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame_sched.sv
// Shares one UART byte transmitter among NUM_REQ 32-bit word publishers.
// Optional test frame (AA 69 val 55) enabled by UART_TX_SCHED_TEST_FRAME_EN.
module uart_tx_frame_sched
    import uart_frame_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int GAP_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [32*NUM_REQ-1:0]   req_data,
`ifdef UART_TX_SCHED_TEST_FRAME_EN
    input  logic                    test_req,
    input  logic [7:0]              test_val,
    output logic                    test_ack,
`endif
    output logic [NUM_REQ-1:0]      ack,
    output logic                    busy,
    output logic [3:0]              cur_id,
    output logic                    tx_start,
    output logic [7:0]              tx_byte,
    input  logic                    tx_busy,
    input  logic                    tx_done
);

    localparam logic [7:0] GAP_LAST =
        (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam logic [1:0] LAST_FRAME = 2'(FRAMES_PER_WORD - 1);

    state_e               state_q, state_d;
    slot_e                b_q, b_d;
    logic [1:0]           f_q, f_d;
    logic [7:0]           gap_q, gap_d;
    logic [31:0]          shadow_q, shadow_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic [3:0]           cur_id_q, cur_id_d;
    logic                 tx_start_q, tx_start_d;
    logic [7:0]           tx_byte_q, tx_byte_d;

    logic [NUM_REQ-1:0]   gnt;
    logic [3:0]           gnt_idx;
    logic                 gnt_vld;
    logic                 upd;
    logic [31:0]          gnt_word;
    logic [7:0]           cur_byte;
    logic                 is_test;

`ifdef UART_TX_SCHED_TEST_FRAME_EN
    logic                 test_q, test_d;
    logic                 test_ack_q, test_ack_d;

    assign is_test  = test_q;
    assign test_ack = test_ack_q;
`else
    assign is_test  = 1'b0;
`endif

    rr_arbiter #(
        .N       (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .upd     (upd),
        .upd_idx (cur_id_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // select the granted requester's word for the shadow copy
    always_comb begin
        gnt_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_word = req_data[32*i +: 32];
            end
        end
    end

    // byte for the current (frame, slot) position
    always_comb begin
        cur_byte = START_FRAME;
        unique case (b_q)
            SLOT_START: cur_byte = START_FRAME;
            SLOT_PID:   cur_byte = is_test ? TEST_PID : pid_of(cur_id_q, f_q);
            SLOT_VALUE: cur_byte = shadow_q[5'd31 - {f_q, 3'b000} -: 8];
            SLOT_END:   cur_byte = END_FRAME;
        endcase
    end

    // scheduler next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        b_d        = b_q;
        f_d        = f_q;
        gap_d      = gap_q;
        shadow_d   = shadow_q;
        ack_d      = '0;
        busy_d     = busy_q;
        cur_id_d   = cur_id_q;
        tx_start_d = 1'b0;
        tx_byte_d  = tx_byte_q;
        upd        = 1'b0;
`ifdef UART_TX_SCHED_TEST_FRAME_EN
        test_d     = test_q;
        test_ack_d = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
`ifdef UART_TX_SCHED_TEST_FRAME_EN
                if (test_req) begin
                    test_d    = 1'b1;
                    shadow_d  = {test_val, 24'h0};
                    cur_id_d  = TEST_ID;
                    busy_d    = 1'b1;
                    f_d       = '0;
                    b_d       = SLOT_START;
                    tx_byte_d = START_FRAME;
                    state_d   = ST_ISSUE;
                end else
`endif
                if (gnt_vld) begin
`ifdef UART_TX_SCHED_TEST_FRAME_EN
                    test_d    = 1'b0;
`endif
                    shadow_d  = gnt_word;
                    cur_id_d  = gnt_idx;
                    busy_d    = 1'b1;
                    f_d       = '0;
                    b_d       = SLOT_START;
                    tx_byte_d = START_FRAME;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tx_byte_d = cur_byte;
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tx_done) begin
                    if (b_q == SLOT_END) begin
                        b_d = SLOT_START;
                        if (f_q == LAST_FRAME || is_test) begin
                            busy_d   = 1'b0;
                            cur_id_d = '0;
                            state_d  = ST_IDLE;
`ifdef UART_TX_SCHED_TEST_FRAME_EN
                            test_d   = 1'b0;
                            if (is_test) begin
                                test_ack_d = 1'b1;
                            end else
`endif
                            begin
                                upd = 1'b1;
                                for (int i = 0; i < NUM_REQ; i++) begin
                                    ack_d[i] = (cur_id_q == 4'(i));
                                end
                            end
                        end else begin
                            f_d     = f_q + 2'd1;
                            gap_d   = '0;
                            state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_ISSUE;
                        end
                    end else begin
                        b_d     = slot_e'(b_q + 2'd1);
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_ISSUE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            b_q        <= SLOT_START;
            f_q        <= '0;
            gap_q      <= '0;
            shadow_q   <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            cur_id_q   <= '0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= '0;
        end else begin
            state_q    <= state_d;
            b_q        <= b_d;
            f_q        <= f_d;
            gap_q      <= gap_d;
            shadow_q   <= shadow_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            cur_id_q   <= cur_id_d;
            tx_start_q <= tx_start_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

`ifdef UART_TX_SCHED_TEST_FRAME_EN
    // test-frame mode and completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            test_q     <= 1'b0;
            test_ack_q <= 1'b0;
        end else begin
            test_q     <= test_d;
            test_ack_q <= test_ack_d;
        end
    end
`endif

    assign ack      = ack_q;
    assign busy     = busy_q;
    assign cur_id   = cur_id_q;
    assign tx_start = tx_start_q;
    assign tx_byte  = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_frame_sched.sv
// Directed bench for uart_tx_frame_sched with a 10-cycle byte UART model.
// u_dut: NUM_REQ=2, no gap; u_gap: NUM_REQ=1, GAP_CYCLES=5.
module tb_uart_tx_frame_sched;

    localparam int BYTE_CYC = 10;
    localparam int BUDGET   = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // dut 0 signals
    logic [1:0]  req0  = '0;
    logic [63:0] data0 = '0;
    logic [1:0]  ack0;
    logic        busy0;
    logic [3:0]  id0;
    logic        st0;
    logic [7:0]  byte0;
    logic        mb0 = 1'b0;
    logic        md0 = 1'b0;
    logic        hold = 1'b0;
    int          mc0 = 0;

    // dut 1 signals
    logic [0:0]  req1  = '0;
    logic [31:0] data1 = '0;
    logic [0:0]  ack1;
    logic        busy1;
    logic [3:0]  id1;
    logic        st1;
    logic [7:0]  byte1;
    logic        mb1 = 1'b0;
    logic        md1 = 1'b0;
    int          mc1 = 0;

`ifdef UART_TX_SCHED_TEST_FRAME_EN
    logic        treq  = 1'b0;
    logic [7:0]  tval  = '0;
    logic        tack;
    logic        treq1 = 1'b0;
    logic        tack1;
    int          tack_n = 0;
`endif

    uart_tx_frame_sched #(
        .NUM_REQ    (2),
        .GAP_CYCLES (0)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req0),
        .req_data (data0),
`ifdef UART_TX_SCHED_TEST_FRAME_EN
        .test_req (treq),
        .test_val (tval),
        .test_ack (tack),
`endif
        .ack      (ack0),
        .busy     (busy0),
        .cur_id   (id0),
        .tx_start (st0),
        .tx_byte  (byte0),
        .tx_busy  (mb0 | hold),
        .tx_done  (md0)
    );

    uart_tx_frame_sched #(
        .NUM_REQ    (1),
        .GAP_CYCLES (5)
    ) u_gap (
        .clk      (clk),
        .rst      (rst),
        .req      (req1),
        .req_data (data1),
`ifdef UART_TX_SCHED_TEST_FRAME_EN
        .test_req (treq1),
        .test_val (8'h00),
        .test_ack (tack1),
`endif
        .ack      (ack1),
        .busy     (busy1),
        .cur_id   (id1),
        .tx_start (st1),
        .tx_byte  (byte1),
        .tx_busy  (mb1),
        .tx_done  (md1)
    );

    logic [7:0] b0q[$];
    int         s0q[$];
    logic [7:0] b1q[$];
    int         s1q[$];
    int         d1q[$];
    int         d0n = 0;
    int         a00 = 0;
    int         a01 = 0;

    // UART model + logger for u_dut
    always @(posedge clk) begin
        if (md0) d0n <= d0n + 1;
        if (ack0[0]) a00 <= a00 + 1;
        if (ack0[1]) a01 <= a01 + 1;
`ifdef UART_TX_SCHED_TEST_FRAME_EN
        if (tack) tack_n <= tack_n + 1;
`endif
        if (rst) begin
            mb0 <= 1'b0;
            md0 <= 1'b0;
            mc0 <= 0;
        end else begin
            md0 <= 1'b0;
            if (st0) begin
                mb0 <= 1'b1;
                mc0 <= BYTE_CYC;
                b0q.push_back(byte0);
                s0q.push_back(cyc);
            end else if (mb0) begin
                mc0 <= mc0 - 1;
                if (mc0 == 1) begin
                    mb0 <= 1'b0;
                    md0 <= 1'b1;
                end
            end
        end
    end

    // UART model + logger for u_gap
    always @(posedge clk) begin
        if (md1) d1q.push_back(cyc);
        if (rst) begin
            mb1 <= 1'b0;
            md1 <= 1'b0;
            mc1 <= 0;
        end else begin
            md1 <= 1'b0;
            if (st1) begin
                mb1 <= 1'b1;
                mc1 <= BYTE_CYC;
                b1q.push_back(byte1);
                s1q.push_back(cyc);
            end else if (mb1) begin
                mc1 <= mc1 - 1;
                if (mc1 == 1) begin
                    mb1 <= 1'b0;
                    md1 <= 1'b1;
                end
            end
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack0(input int idx, input string tag);
        for (int k = 0; k < BUDGET && ack0[idx] !== 1'b1; k++) begin
            @(negedge clk);
        end
        chk(tag, 32'(ack0[idx] === 1'b1), 32'd1);
    endtask

    initial begin
        logic [7:0] exp1 [16];
        logic [1:0] seq [4];
        int         base;
        int         rc;
        int         n;
        int         bad_st;
        int         bad_by;
        int         bad_bz;
        int         dn;

        exp1 = '{8'hAA, 8'h10, 8'h12, 8'h55, 8'hAA, 8'h11, 8'h34, 8'h55,
                 8'hAA, 8'h12, 8'h56, 8'h55, 8'hAA, 8'h13, 8'h78, 8'h55};

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack0), 32'h0);
        chk("rst_busy", 32'(busy0), 32'h0);
        chk("rst_cur_id", 32'(id0), 32'h0);
        chk("rst_tx_start", 32'(st0), 32'h0);
        chk("rst_tx_byte", 32'(byte0), 32'h0);
        chk("rst_busy_gap", 32'(busy1), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // contention: both held, expect 0,1,0,1
        base  = b0q.size();
        data0 = {32'hBBBB0002, 32'hAAAA0001};
        req0  = 2'b11;
        n     = 0;
        for (int k = 0; k < 4 * BUDGET && n < 4; k++) begin
            @(negedge clk);
            if (ack0 != 2'b00) begin
                seq[n] = ack0;
                n++;
                if (n == 4) req0 = 2'b00;
            end
        end
        chk("rr_ack_count", 32'(n), 32'd4);
        chk("rr_ack_0", 32'(seq[0]), 32'h1);
        chk("rr_ack_1", 32'(seq[1]), 32'h2);
        chk("rr_ack_2", 32'(seq[2]), 32'h1);
        chk("rr_ack_3", 32'(seq[3]), 32'h2);
        for (int k = 0; k < 4; k++) begin
            chk("rr_pid_req1", 32'(b0q[base + 16 + 4*k + 1]), 32'h20 + 32'(k));
        end
        chk("rr_val_req1", {b0q[base+18], b0q[base+22], b0q[base+26],
                            b0q[base+30]}, 32'hBBBB0002);
        chk("rr_val_req0", {b0q[base+2], b0q[base+6], b0q[base+10],
                            b0q[base+14]}, 32'hAAAA0001);
        repeat (5) @(negedge clk);
        chk("rr_idle_after", 32'(busy0), 32'h0);

        // single word, req dropped and data changed after grant
        base  = b0q.size();
        n     = a00;
        data0 = {32'h0, 32'h12345678};
        req0  = 2'b01;
        rc    = cyc;
        @(negedge clk);
        chk("sw_busy_grant", 32'(busy0), 32'h1);
        @(negedge clk);
        chk("sw_first_start", 32'(st0), 32'h1);
        req0  = 2'b00;
        data0 = {32'h0, 32'hDEADBEEF};
        wait_ack0(0, "sw_ack_timeout");
        repeat (5) @(negedge clk);
        chk("sw_byte_count", 32'(b0q.size() - base), 32'd16);
        for (int k = 0; k < 16; k++) begin
            chk("sw_byte", 32'(b0q[base + k]), 32'(exp1[k]));
        end
        chk("sw_latency", 32'(s0q[base] - rc), 32'd2);
        chk("sw_ack_once", 32'(a00 - n), 32'd1);
        chk("sw_busy_end", 32'(busy0), 32'h0);

        // backpressure: tx_busy held for 50 cycles at grant
        base   = b0q.size();
        hold   = 1'b1;
        data0  = {32'h0, 32'h0F0E0D0C};
        req0   = 2'b01;
        bad_st = 0;
        bad_by = 0;
        bad_bz = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (st0 !== 1'b0) bad_st++;
            if (byte0 !== 8'hAA) bad_by++;
            if (busy0 !== 1'b1) bad_bz++;
        end
        chk("bp_no_start", 32'(bad_st), 32'd0);
        chk("bp_byte_aa", 32'(bad_by), 32'd0);
        chk("bp_busy", 32'(bad_bz), 32'd0);
        hold = 1'b0;
        req0 = 2'b00;
        @(negedge clk);
        chk("bp_release_start", 32'(st0), 32'h1);
        wait_ack0(0, "bp_ack_timeout");
        chk("bp_first_byte", 32'(b0q[base]), 32'hAA);
        chk("bp_last_val", 32'(b0q[base + 14]), 32'h0C);

        // gap: GAP_CYCLES=5 on single-requester instance
        req1  = 1'b1;
        data1 = 32'h01020304;
        for (int k = 0; k < BUDGET && ack1[0] !== 1'b1; k++) begin
            @(negedge clk);
            if (busy1) req1 = 1'b0;
        end
        chk("gap_ack", 32'(ack1[0]), 32'h1);
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("gap_byte_count", 32'(b1q.size()), 32'd16);
        chk("gap_done_count", 32'(d1q.size()), 32'd16);
        for (int k = 0; k < 15; k++) begin
            if (k % 4 == 3) begin
                chk("gap_after_end", 32'(s1q[k + 1] - d1q[k]), 32'd7);
            end else begin
                chk("gap_in_frame", 32'(s1q[k + 1] - d1q[k]), 32'd2);
            end
        end
        chk("gap_pid", 32'(b1q[13]), 32'h13);
        chk("gap_val", 32'(b1q[14]), 32'h04);

        // reset mid-word after the 6th tx_done, while tx_start is high
        dn    = d0n;
        data0 = {32'h0, 32'h11223344};
        req0  = 2'b01;
        for (int k = 0; k < BUDGET && (d0n - dn) < 6; k++) @(negedge clk);
        req0 = 2'b00;
        for (int k = 0; k < 20 && st0 !== 1'b1; k++) @(negedge clk);
        chk("mr_start_seen", 32'(st0), 32'h1);
        n   = a00;
        rst = 1'b1;
        #1;
        chk("mr_tx_start", 32'(st0), 32'h0);
        chk("mr_busy", 32'(busy0), 32'h0);
        chk("mr_ack", 32'(ack0), 32'h0);
        chk("mr_cur_id", 32'(id0), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mr_no_ack", 32'(a00 - n), 32'd0);

        // after reset the pointer is 0 again, then req[1] alone
        base  = b0q.size();
        data0 = {32'h55667788, 32'h99AABBCC};
        req0  = 2'b11;
        @(negedge clk);
        chk("mr_regrant_busy", 32'(busy0), 32'h1);
        chk("mr_regrant_id", 32'(id0), 32'h0);
        req0 = 2'b10;
        wait_ack0(0, "mr_ack0_timeout");
        wait_ack0(1, "mr_ack1_timeout");
        req0 = 2'b00;
        chk("mr_w0_first", 32'(b0q[base]), 32'hAA);
        chk("mr_w0_pid", 32'(b0q[base + 1]), 32'h10);
        chk("mr_w1_first", 32'(b0q[base + 16]), 32'hAA);
        chk("mr_w1_pid", 32'(b0q[base + 17]), 32'h20);
        chk("mr_w1_val", 32'(b0q[base + 18]), 32'h55);

`ifdef UART_TX_SCHED_TEST_FRAME_EN
        // test frame has priority over requester 0
        @(negedge clk);
        base  = b0q.size();
        n     = tack_n;
        data0 = {32'h0, 32'hCAFEF00D};
        tval  = 8'h3C;
        treq  = 1'b1;
        req0  = 2'b01;
        @(negedge clk);
        treq = 1'b0;
        chk("tf_cur_id", 32'(id0), 32'hF);
        for (int k = 0; k < BUDGET && tack !== 1'b1; k++) @(negedge clk);
        chk("tf_ack", 32'(tack), 32'h1);
        wait_ack0(0, "tf_word_ack");
        req0 = 2'b00;
        chk("tf_b0", 32'(b0q[base]), 32'hAA);
        chk("tf_b1", 32'(b0q[base + 1]), 32'h69);
        chk("tf_b2", 32'(b0q[base + 2]), 32'h3C);
        chk("tf_b3", 32'(b0q[base + 3]), 32'h55);
        chk("tf_next_pid", 32'(b0q[base + 5]), 32'h10);
        chk("tf_ack_once", 32'(tack_n - n), 32'd1);
`endif

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame_sched.md
Name: uart_tx_frame_sched

Overview:
- Shares one UART byte transmitter among NUM_REQ requesters, each publishing a 32-bit word.
- Each word goes out as four 4-byte frames: 0xAA, PID, VALUE, 0x55.
- Requester i uses PID base (i+1)*0x10; frame k (k=0..3) carries PID base+k and byte req_data[i][31-8k -: 8], MSB first. These are exactly the frames the on-chip RX PID buffer consumes.
- Sits between telemetry/gain sources and uart_tx. Round-robin arbitration, one-cycle completion ack.

Parameters:
- NUM_REQ, 2, number of requesters (1..15).
- GAP_CYCLES, 0, idle clk cycles inserted after each 0x55 byte before the next 0xAA (0..255).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NUM_REQ  level request per requester.
- req_data  in  32*NUM_REQ  word i at [32i+31:32i]; sampled at grant only.
- ack  out  NUM_REQ  one-cycle pulse when requester i's 16 bytes are fully sent.
- busy  out  1  high from grant until ack.
- cur_id  out  4  index of the requester being served; 0 when idle.
- tx_start  out  1  one-cycle pulse; uart_tx loads tx_byte.
- tx_byte  out  8  byte to send; stable from tx_start until the matching tx_done.
- tx_busy  in  1  uart_tx is shifting.
- tx_done  in  1  uart_tx one-cycle pulse, byte finished.

Behaviour:
- Reset values: ack=0, busy=0, cur_id=0, tx_start=0, tx_byte=0x00. Round-robin pointer=0, FSM=IDLE.
- FSM states: IDLE, ISSUE, WAIT, GAP.
- Counters: frame index f (0..3), byte index b (0..3: START, PID, VALUE, END), gap counter.
- IDLE:
  - If any req bit is set, grant the first set bit at or after the pointer, wrapping around.
  - Latch that word into a shadow register; set cur_id and busy.
  - Clear f and b. Go to ISSUE on the next cycle.
- ISSUE:
  - Drive tx_byte per (f,b).
  - When tx_busy=0, pulse tx_start for one cycle and go to WAIT.
  - While tx_busy=1, hold.
- WAIT:
  - On tx_done, advance b.
  - If b wraps past END: advance f.
    - If f wraps past 3: word done. Pulse ack[cur_id] next cycle, set pointer=cur_id+1 (mod NUM_REQ), go to IDLE.
    - Otherwise, go to GAP when GAP_CYCLES>0, else ISSUE.
  - Otherwise (b did not wrap), go to ISSUE.
- GAP: count GAP_CYCLES cycles, then go to ISSUE.
- Latency:
  - req rises in IDLE at cycle 0 → tx_start at cycle 2 (tx_busy=0).
  - Each following byte: tx_start 1 cycle after the previous byte's ISSUE entry, i.e. tx_done+1 → ISSUE, tx_start at tx_done+1.
- ack timing: busy falls on the same edge ack rises. A new grant is possible on the cycle after ack.
- req deassert after grant: the word still completes and ack is still issued.
- req_data changes mid-word: ignored, because the shadow copy is used.
- tx_done while not in WAIT: ignored.
- Simultaneous requests: round-robin. A requester holding req continuously is re-served only after every other pending requester.
- NUM_REQ=1: pointer fixed at 0.
- Reset mid-operation: tx_start drops immediately and the word is abandoned with no ack. After release, arbitration restarts from pointer 0. The downstream RX buffer discards the partial frame.

Optional Feature:
- Macro: UART_TX_SCHED_TEST_FRAME_EN.
- With the macro:
  - Extra inputs test_req (1) and test_val (8); extra output test_ack (1).
  - test_req has absolute priority at each IDLE grant.
  - Sends a single frame: 0xAA, 0x69, test_val, 0x55.
  - test_ack pulses one cycle after the final tx_done. cur_id=0xF while serving. Round-robin pointer unchanged.
  - A test request never preempts a word in progress.
- Without the macro: the ports do not exist, and PID 0x69 is never emitted.

Decomposition:
- Package uart_frame_pkg:
  - START_FRAME=0xAA, END_FRAME=0x55, TEST_PID=0x69.
  - PID_STRIDE=0x10, FRAMES_PER_WORD=4.
  - Byte-slot enum (START/PID/VALUE/END).
  - FSM state enum.
  - Shared with the RX PID buffer.
- Sub-module rr_arbiter: NUM_REQ-wide round-robin, one-hot grant plus index, pointer advanced by an update strobe.

Test Plan:
- Single word: req[0]=1, req_data[0]=0x12345678, tx model 10-cycle bytes → bytes AA 10 12 55 AA 11 34 55 AA 12 56 55 AA 13 78 55; ack[0] pulses once.
- Contention: req=2'b11 held, data0=0xAAAA0001, data1=0xBBBB0002 → order 0,1,0,1; requester 1 PIDs 0x20..0x23; acks alternate.
- Backpressure: tx_busy held high for 50 cycles at grant → tx_start not asserted until tx_busy=0; tx_byte=0xAA stable throughout.
- Gap: GAP_CYCLES=5 → exactly 5 idle cycles between each tx_done(0x55) and the next tx_start; none inside a frame.
- Reset mid-word: assert rst after the 6th tx_done → tx_start, busy, ack=0 immediately; after release, req[1] alone is granted first byte 0xAA.
- With UART_TX_SCHED_TEST_FRAME_EN: test_req and req[0] set together, test_val=0x3C → AA 69 3C 55, test_ack, then the requester-0 word.
